// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter (start, LSB-first data,
// optional parity, 1 or 2 stop bits) with a send_start/busy handshake and a
// one-cycle done pulse on the last stop-bit cycle.
// Optional line-break generation is enabled with `define UART_TX_BREAK_EN.
module uart_tx_frame #(
  parameter int CLOCKS_PER_BIT = 217,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS      = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 send_start,
  input  logic [DATA_BITS-1:0] to_send,
`ifdef UART_TX_BREAK_EN
  input  logic                 break_req,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 out
);
  localparam int BW = $clog2(CLOCKS_PER_BIT);
  localparam int NW = $clog2(DATA_BITS + 2);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`endif

  state_t               state, state_n;
  logic [BW-1:0]        baud_cnt, baud_n;
  logic [NW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_n;
  logic                 out_n, busy_n, done_n;
  logic                 accept, last_baud;

  // A new frame is taken whenever the line is not busy; this includes the
  // done cycle, which gives back-to-back frames with no idle gap.
  assign accept    = send_start && !busy;
  assign last_baud = (baud_cnt == BW'(CLOCKS_PER_BIT - 1));

  // State, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      out      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      par_bit  <= par_n;
      out      <= out_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Next-state, counter sequencing and next output values.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    par_n   = par_bit;
    if (accept) begin
      state_n = S_START;
      baud_n  = '0;
      bit_n   = '0;
      shreg_n = to_send;
      // Even parity makes the total count of ones even; odd inverts it.
      par_n   = (PARITY == 1) ? ~(^to_send) : (^to_send);
    end else begin
      unique case (state)
        S_IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (break_req) begin
            state_n = S_BREAK;
            baud_n  = '0;
            bit_n   = '0;
          end
`endif
        end
        S_START: begin
          if (last_baud) begin
            state_n = S_DATA;
            baud_n  = '0;
            bit_n   = '0;
          end else baud_n = baud_cnt + 1'b1;
        end
        S_DATA: begin
          if (last_baud) begin
            baud_n  = '0;
            shreg_n = shreg >> 1;
            if (bit_cnt == NW'(DATA_BITS - 1)) begin
              state_n = (PARITY != 0) ? S_PARITY : S_STOP;
              bit_n   = '0;
            end else bit_n = bit_cnt + 1'b1;
          end else baud_n = baud_cnt + 1'b1;
        end
        S_PARITY: begin
          if (last_baud) begin
            state_n = S_STOP;
            baud_n  = '0;
            bit_n   = '0;
          end else baud_n = baud_cnt + 1'b1;
        end
        S_STOP: begin
          if (last_baud) begin
            baud_n = '0;
            if (bit_cnt == NW'(STOP_BITS - 1)) begin
              state_n = S_IDLE;
              bit_n   = '0;
            end else bit_n = bit_cnt + 1'b1;
          end else baud_n = baud_cnt + 1'b1;
        end
`ifdef UART_TX_BREAK_EN
        // bit_cnt 0: holding the line low; 1: one bit time of mark after release.
        S_BREAK: begin
          if (bit_cnt == '0) begin
            if (!break_req) begin
              bit_n  = NW'(1);
              baud_n = '0;
            end
          end else if (last_baud) begin
            state_n = S_IDLE;
            bit_n   = '0;
            baud_n  = '0;
          end else baud_n = baud_cnt + 1'b1;
        end
`endif
        default: state_n = S_IDLE;
      endcase
    end

    unique case (state_n)
      S_START:  out_n = 1'b0;
      S_DATA:   out_n = shreg_n[0];
      S_PARITY: out_n = par_n;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  out_n = (bit_n != '0);
`endif
      default:  out_n = 1'b1;
    endcase

    // The final stop-bit cycle reports done and drops busy so a new request
    // can be accepted on that same edge.
    done_n = (state_n == S_STOP) && (bit_n == NW'(STOP_BITS - 1)) &&
             (baud_n == BW'(CLOCKS_PER_BIT - 1));
    busy_n = (state_n != S_IDLE) && !done_n;
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four instances with different configurations,
// a per-cycle expected-waveform model built from frame bit lists, plus
// hand-computed frame lengths and bit patterns.
module tb_uart_tx_frame;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ss;
  logic [8:0] ts [4];
  logic       brk;
  logic [3:0] so, sb, sd;

  always #5 clk = ~clk;

  // d0: 217/8N1, d1: 4/7E2, d2: 4/7O2, d3: 4/8N1
  uart_tx_frame #(.CLOCKS_PER_BIT(217), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) d0 (
    .clock(clk), .reset(rst), .send_start(ss[0]), .to_send(ts[0][7:0]),
`ifdef UART_TX_BREAK_EN
    .break_req(1'b0),
`endif
    .busy(sb[0]), .done(sd[0]), .out(so[0]));
  uart_tx_frame #(.CLOCKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) d1 (
    .clock(clk), .reset(rst), .send_start(ss[1]), .to_send(ts[1][6:0]),
`ifdef UART_TX_BREAK_EN
    .break_req(1'b0),
`endif
    .busy(sb[1]), .done(sd[1]), .out(so[1]));
  uart_tx_frame #(.CLOCKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) d2 (
    .clock(clk), .reset(rst), .send_start(ss[2]), .to_send(ts[2][6:0]),
`ifdef UART_TX_BREAK_EN
    .break_req(1'b0),
`endif
    .busy(sb[2]), .done(sd[2]), .out(so[2]));
  uart_tx_frame #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) d3 (
    .clock(clk), .reset(rst), .send_start(ss[3]), .to_send(ts[3][7:0]),
`ifdef UART_TX_BREAK_EN
    .break_req(brk),
`endif
    .busy(sb[3]), .done(sd[3]), .out(so[3]));

  function automatic int cpb_of(int i); return (i == 0) ? 217 : 4; endfunction
  function automatic int db_of(int i);  return (i == 1 || i == 2) ? 7 : 8; endfunction
  function automatic int par_of(int i); return (i == 1) ? 2 : ((i == 2) ? 1 : 0); endfunction
  function automatic int sb_of(int i);  return (i == 1 || i == 2) ? 2 : 1; endfunction

  typedef logic [2:0] ent_t;   // {out, busy, done} expected for one cycle
  ent_t exq [4][$];
  bit   in_brk;
  int   ncmp = 0, nfail = 0;
  int   dcnt [4];
  bit   chk_en = 1'b0;

  // Expand one frame into its per-cycle line values.
  function automatic void push_frame(int i, logic [8:0] d);
    logic b [$];
    logic p;
    int   n, cpb;
    cpb = cpb_of(i);
    p   = 1'b0;
    b.push_back(1'b0);
    for (int k = 0; k < db_of(i); k++) begin
      b.push_back(d[k]);
      p = p ^ d[k];
    end
    if (par_of(i) == 2) b.push_back(p);
    if (par_of(i) == 1) b.push_back(~p);
    for (int k = 0; k < sb_of(i); k++) b.push_back(1'b1);
    n = b.size() * cpb;
    for (int k = 0; k < n; k++) exq[i].push_back({b[k / cpb], k != n - 1, k == n - 1});
  endfunction

  // Model: consume the cycle that just ended, then apply reset/accept/break.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      ent_t prev;
      bit   was_idle;
      was_idle = (exq[i].size() == 0);
      prev = 3'b100;
      if (!was_idle) prev = exq[i].pop_front();
      if (rst) begin
        exq[i].delete();
        if (i == 3) in_brk = 1'b0;
      end else if (ss[i] && !prev[1]) begin
        push_frame(i, ts[i]);
      end else if (i == 3) begin
        if (in_brk) begin
          if (brk) exq[i].push_back(3'b010);
          else begin
            for (int k = 0; k < cpb_of(i); k++) exq[i].push_back(3'b110);
            in_brk = 1'b0;
          end
        end else if (was_idle && brk) begin
          in_brk = 1'b1;
          exq[i].push_back(3'b010);
        end
      end
    end
  end

  // Compare every instance against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        ent_t e;
        e = (exq[i].size() > 0) ? exq[i][0] : 3'b100;
        ncmp++;
        if ({so[i], sb[i], sd[i]} !== e) begin
          nfail++;
          $display("FAIL model_d%0d t=%0t out/busy/done=%b required %b", i, $time, {so[i], sb[i], sd[i]}, e);
        end
        if (sd[i] === 1'b1) dcnt[i]++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Send one frame and record its length (first start cycle to done,
  // inclusive) and the line value sampled mid-way through each bit.
  task automatic run_frame(input int i, input logic [8:0] d, output int len, output logic [15:0] bits);
    int c, cpb;
    cpb  = cpb_of(i);
    bits = '0;
    @(negedge clk); ss[i] = 1'b1; ts[i] = d;
    @(negedge clk); ss[i] = 1'b0;
    c = 1;
    while (c < 5000) begin
      if ((c - 1) % cpb == cpb / 2 && (c - 1) / cpb < 16) bits[(c - 1) / cpb] = so[i];
      if (sd[i] === 1'b1) break;
      @(negedge clk); c++;
    end
    len = c;
  endtask

  initial begin
    int          len, c, d0cnt, cnt;
    logic [15:0] bits;
    rst = 1'b1; ss = '0; brk = 1'b0;
    for (int i = 0; i < 4; i++) begin ts[i] = '0; dcnt[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_out",  32'(so), 32'hF);
    chk("rst_busy", 32'(sb), 32'h0);
    chk("rst_done", 32'(sd), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // 8N1 0xA5 with an ignored 0x55 request at cycle 10 of the frame.
    d0cnt = dcnt[0];
    fork
      run_frame(0, 9'h0A5, len, bits);
      begin
        repeat (11) @(negedge clk);
        ss[0] = 1'b1; ts[0] = 9'h055;
        @(negedge clk); ss[0] = 1'b0;
      end
    join
    chk("a5_len", len, 2170);
    chk("a5_bits", 32'(bits[9:0]), 32'h34A);
    repeat (300) @(negedge clk);
    chk("a5_done_once", dcnt[0] - d0cnt, 1);

    // 7-bit, two stop bits, even then odd parity on 0x41.
    run_frame(1, 9'h041, len, bits);
    chk("7e2_len", len, 44);
    chk("7e2_bits", 32'(bits[10:0]), 32'h682);
    run_frame(2, 9'h041, len, bits);
    chk("7o2_len", len, 44);
    chk("7o2_bits", 32'(bits[10:0]), 32'h782);

    // Back-to-back: send_start held across the done cycle.
    @(negedge clk); ss[3] = 1'b1; ts[3] = 9'h000;
    @(negedge clk); ts[3] = 9'h0FF;
    c = 1;
    while (sd[3] !== 1'b1 && c < 200) begin @(negedge clk); c++; end
    chk("b2b_len1", c, 40);
    @(negedge clk);
    chk("b2b_gap_out", 32'(so[3]), 0);
    chk("b2b_gap_busy", 32'(sb[3]), 1);
    ss[3] = 1'b0;
    c = 1;
    while (sd[3] !== 1'b1 && c < 200) begin @(negedge clk); c++; end
    chk("b2b_len2", c, 40);
    repeat (5) @(negedge clk);

    // Reset in the middle of the data bits, then a clean frame.
    @(negedge clk); ss[3] = 1'b1; ts[3] = 9'h0A5;
    @(negedge clk); ss[3] = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_out",  32'(so[3]), 1);
    chk("rst_mid_busy", 32'(sb[3]), 0);
    chk("rst_mid_done", 32'(sd[3]), 0);
    rst = 1'b0;
    run_frame(3, 9'h0A5, len, bits);
    chk("post_rst_len", len, 40);
    chk("post_rst_bits", 32'(bits[9:0]), 32'h34A);
    repeat (5) @(negedge clk);

`ifdef UART_TX_BREAK_EN
    // Break held for 30 cycles, then one bit time of mark, no done.
    d0cnt = dcnt[3];
    @(negedge clk); brk = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (so[3] === 1'b0 && sb[3] === 1'b1) cnt++;
    end
    brk = 1'b0;
    chk("brk_low_cycles", cnt, 30);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (so[3] === 1'b1 && sb[3] === 1'b1) cnt++;
    end
    chk("brk_mark_cycles", cnt, 4);
    @(negedge clk);
    chk("brk_end_busy", 32'(sb[3]), 0);
    chk("brk_no_done", dcnt[3] - d0cnt, 0);
    repeat (5) @(negedge clk);
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
